// File: rtl/render_pkg.sv
// ---------------------------------------------------------------------------
// render_pkg
// Definitions shared by the shape renderers: FSM state type, draw-mode
// encodings and the default coordinate / size / colour widths.
// ---------------------------------------------------------------------------
package render_pkg;

  localparam int DEF_X_WIDTH     = 8;
  localparam int DEF_Y_WIDTH     = 7;
  localparam int DEF_SIZE_WIDTH  = 8;
  localparam int DEF_COLOR_WIDTH = 3;

  localparam logic MODE_FILL    = 1'b0;
  localparam logic MODE_OUTLINE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rect_scan_counter.sv
// ---------------------------------------------------------------------------
// rect_scan_counter
// Walks the (dx, dy) offsets of a rectangle in raster order. In outline
// mode, interior rows jump from dx = 0 straight to dx = w-1.
//
// Ports
//   i_clock    clock, posedge
//   i_reset    synchronous active-high reset (clears dx, dy)
//   i_load     start of job: clear dx, dy
//   i_advance  current pixel accepted, step to the next offset
//   i_mode     MODE_FILL / MODE_OUTLINE
//   i_w_m1     latched width - 1
//   i_h_m1     latched height - 1
//   o_dx_nxt   dx of the pixel after the current one
//   o_dy_nxt   dy of the pixel after the current one
//   o_last     current offset is the final pixel of the job
// ---------------------------------------------------------------------------
module rect_scan_counter
  import render_pkg::*;
#(
  parameter int SIZE_WIDTH = DEF_SIZE_WIDTH
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_load,
  input  logic                  i_advance,
  input  logic                  i_mode,
  input  logic [SIZE_WIDTH-1:0] i_w_m1,
  input  logic [SIZE_WIDTH-1:0] i_h_m1,
  output logic [SIZE_WIDTH-1:0] o_dx_nxt,
  output logic [SIZE_WIDTH-1:0] o_dy_nxt,
  output logic                  o_last
);

  logic [SIZE_WIDTH-1:0] r_dx;
  logic [SIZE_WIDTH-1:0] r_dy;
  logic                  w_row_end;
  logic                  w_edge_row;

  assign w_row_end  = (r_dx == i_w_m1);
  assign w_edge_row = (r_dy == '0) || (r_dy == i_h_m1);
  assign o_last     = w_row_end && (r_dy == i_h_m1);

  // Row end has priority, so a 1-wide outline never revisits dx = 0 and
  // a 2-wide interior row degenerates to an ordinary increment.
  always_comb begin
    o_dx_nxt = r_dx;
    o_dy_nxt = r_dy;
    if (w_row_end) begin
      o_dx_nxt = '0;
      o_dy_nxt = r_dy + SIZE_WIDTH'(1);
    end else if ((i_mode == MODE_OUTLINE) && !w_edge_row) begin
      o_dx_nxt = i_w_m1;
    end else begin
      o_dx_nxt = r_dx + SIZE_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset || i_load) begin
      r_dx <= '0;
      r_dy <= '0;
    end else if (i_advance) begin
      if (o_last) begin
        r_dx <= '0;
        r_dy <= '0;
      end else begin
        r_dx <= o_dx_nxt;
        r_dy <= o_dy_nxt;
      end
    end
  end

endmodule

// File: rtl/rect_renderer.sv
// ---------------------------------------------------------------------------
// rect_renderer
// Rasterises an axis-aligned rectangle (filled or outline) into a stream of
// pixel coordinates plus colour over a valid/ready handshake.
//
// Ports
//   i_clock, i_reset          clock (posedge), synchronous active-high reset
//   i_start                   job request, sampled only in IDLE
//   i_origin_x, i_origin_y    top-left corner
//   i_rect_w, i_rect_h        size in pixels (0 in either = empty job)
//   i_color, i_mode           pixel colour, MODE_FILL / MODE_OUTLINE
//   o_out_x, o_out_y          registered pixel coordinate (wraps, no clip)
//   o_out_color               registered pixel colour
//   o_out_valid, i_out_ready  pixel handshake
//   o_busy                    job in progress (DRAW or DONE)
//   o_has_finished            one-cycle pulse at the end of a job
//
// State | meaning
// IDLE  | waiting for i_start
// DRAW  | presenting pixels, advancing on each handshake
// DONE  | has_finished pulse, back to IDLE next cycle
// ---------------------------------------------------------------------------
module rect_renderer
  import render_pkg::*;
#(
  parameter int X_WIDTH     = DEF_X_WIDTH,
  parameter int Y_WIDTH     = DEF_Y_WIDTH,
  parameter int SIZE_WIDTH  = DEF_SIZE_WIDTH,
  parameter int COLOR_WIDTH = DEF_COLOR_WIDTH
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [X_WIDTH-1:0]     i_origin_x,
  input  logic [Y_WIDTH-1:0]     i_origin_y,
  input  logic [SIZE_WIDTH-1:0]  i_rect_w,
  input  logic [SIZE_WIDTH-1:0]  i_rect_h,
  input  logic [COLOR_WIDTH-1:0] i_color,
  input  logic                   i_mode,
  output logic [X_WIDTH-1:0]     o_out_x,
  output logic [Y_WIDTH-1:0]     o_out_y,
  output logic [COLOR_WIDTH-1:0] o_out_color,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic                   o_busy,
  output logic                   o_has_finished
);

  state_t r_state;
  state_t w_state_nxt;

  logic [X_WIDTH-1:0]     r_org_x;
  logic [Y_WIDTH-1:0]     r_org_y;
  logic [SIZE_WIDTH-1:0]  r_w_m1;
  logic [SIZE_WIDTH-1:0]  r_h_m1;
  logic                   r_mode;

  logic [X_WIDTH-1:0]     r_out_x;
  logic [Y_WIDTH-1:0]     r_out_y;
  logic [COLOR_WIDTH-1:0] r_out_color;
  logic                   r_out_valid;

  logic                   w_load;
  logic                   w_handshake;
  logic                   w_last;
  logic [SIZE_WIDTH-1:0]  w_dx_nxt;
  logic [SIZE_WIDTH-1:0]  w_dy_nxt;

  rect_scan_counter #(
    .SIZE_WIDTH (SIZE_WIDTH)
  ) u_scan (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_load    (w_load),
    .i_advance (w_handshake),
    .i_mode    (r_mode),
    .i_w_m1    (r_w_m1),
    .i_h_m1    (r_h_m1),
    .o_dx_nxt  (w_dx_nxt),
    .o_dy_nxt  (w_dy_nxt),
    .o_last    (w_last)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_handshake = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          if ((i_rect_w == '0) || (i_rect_h == '0)) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_DRAW;
            w_load      = 1'b1;
          end
        end
      end
      ST_DRAW: begin
        w_handshake = r_out_valid && i_out_ready;
        if (w_handshake && w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output registers are loaded with the *next* pixel on each handshake so
  // the coordinate presented is always a flop, never a live adder output.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_org_x     <= '0;
      r_org_y     <= '0;
      r_w_m1      <= '0;
      r_h_m1      <= '0;
      r_mode      <= MODE_FILL;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_out_color <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_org_x     <= i_origin_x;
      r_org_y     <= i_origin_y;
      r_w_m1      <= i_rect_w - SIZE_WIDTH'(1);
      r_h_m1      <= i_rect_h - SIZE_WIDTH'(1);
      r_mode      <= i_mode;
      r_out_x     <= i_origin_x;
      r_out_y     <= i_origin_y;
      r_out_color <= i_color;
      r_out_valid <= 1'b1;
    end else if (w_handshake) begin
      if (w_last) begin
        r_out_valid <= 1'b0;
      end else begin
        r_out_x <= r_org_x + X_WIDTH'(w_dx_nxt);
        r_out_y <= r_org_y + Y_WIDTH'(w_dy_nxt);
      end
    end
  end

  assign o_out_x        = r_out_x;
  assign o_out_y        = r_out_y;
  assign o_out_color    = r_out_color;
  assign o_out_valid    = r_out_valid;
  assign o_busy         = (r_state != ST_IDLE);
  assign o_has_finished = (r_state == ST_DONE);

endmodule

// File: tb/tb_rect_renderer.sv
module tb_rect_renderer;

  localparam int XW = 8;
  localparam int YW = 7;
  localparam int SW = 8;
  localparam int CW = 3;
  localparam int LIMIT = 2000;

  logic          clk;
  logic          i_reset;
  logic          i_start;
  logic [XW-1:0] i_origin_x;
  logic [YW-1:0] i_origin_y;
  logic [SW-1:0] i_rect_w;
  logic [SW-1:0] i_rect_h;
  logic [CW-1:0] i_color;
  logic          i_mode;
  logic [XW-1:0] o_out_x;
  logic [YW-1:0] o_out_y;
  logic [CW-1:0] o_out_color;
  logic          o_out_valid;
  logic          i_out_ready;
  logic          o_busy;
  logic          o_has_finished;

  int n_checks;
  int n_pass;

  rect_renderer dut (
    .i_clock        (clk),
    .i_reset        (i_reset),
    .i_start        (i_start),
    .i_origin_x     (i_origin_x),
    .i_origin_y     (i_origin_y),
    .i_rect_w       (i_rect_w),
    .i_rect_h       (i_rect_h),
    .i_color        (i_color),
    .i_mode         (i_mode),
    .o_out_x        (o_out_x),
    .o_out_y        (o_out_y),
    .o_out_color    (o_out_color),
    .o_out_valid    (o_out_valid),
    .i_out_ready    (i_out_ready),
    .o_busy         (o_busy),
    .o_has_finished (o_has_finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one job from an idle DUT. stall: 0 = ready always, 1 = ready on
  // alternate cycles, 2 = random. poke: pulse start again mid-job.
  task automatic run_job(input string name, input int w, input int h,
                         input bit md, input int ox, input int oy,
                         input int col, input int stall, input bit poke);
    bit [XW-1:0] ex_x[$];
    bit [YW-1:0] ex_y[$];
    int          npix;
    int          got;
    int          c;
    int          last_acc;
    int          fin_cycle;
    bit          done;
    bit          prev_stall;
    bit          exp_valid;
    bit          exp_fin;
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic [CW-1:0] pc;
    bit [CW-1:0]   ecol;

    ecol = col[CW-1:0];
    for (int dy = 0; dy < h; dy++)
      for (int dx = 0; dx < w; dx++)
        if (!md || dy == 0 || dy == h - 1 || dx == 0 || dx == w - 1) begin
          ex_x.push_back(XW'((ox + dx) % (1 << XW)));
          ex_y.push_back(YW'((oy + dy) % (1 << YW)));
        end
    npix = ex_x.size();

    i_origin_x = ox[XW-1:0];
    i_origin_y = oy[YW-1:0];
    i_rect_w   = w[SW-1:0];
    i_rect_h   = h[SW-1:0];
    i_color    = ecol;
    i_mode     = md;
    i_start    = 1'b1;
    @(posedge clk); #1;
    i_start    = 1'b0;
    // inputs must not be re-sampled mid-job
    i_origin_x = XW'($urandom);
    i_origin_y = YW'($urandom);
    i_rect_w   = SW'($urandom_range(1, 9));
    i_rect_h   = SW'($urandom_range(1, 9));
    i_color    = CW'($urandom);
    i_mode     = 1'($urandom);

    c = 1; got = 0; last_acc = 0; fin_cycle = -1; done = 0; prev_stall = 0;
    px = '0; py = '0; pc = '0;
    while (!done && c < LIMIT) begin
      case (stall)
        0:       i_out_ready = 1'b1;
        1:       i_out_ready = (c % 2 == 0);
        default: i_out_ready = ($urandom_range(0, 2) != 0);
      endcase
      i_start = (poke && c == 2);

      if (prev_stall) begin
        n_checks++;
        if (o_out_valid !== 1'b1 || o_out_x !== px || o_out_y !== py || o_out_color !== pc)
          $display("FAIL %s hold c=%0d got v=%0b (%0d,%0d,%0d) want v=1 (%0d,%0d,%0d)",
                   name, c, o_out_valid, o_out_x, o_out_y, o_out_color, px, py, pc);
        else n_pass++;
      end

      exp_valid = (got < npix) && (fin_cycle < 0);
      n_checks++;
      if (o_out_valid !== exp_valid)
        $display("FAIL %s valid c=%0d got %0b want %0b", name, c, o_out_valid, exp_valid);
      else n_pass++;

      exp_fin = (got == npix) && (c == last_acc + 1);
      n_checks++;
      if (o_has_finished !== exp_fin)
        $display("FAIL %s has_finished c=%0d got %0b want %0b", name, c, o_has_finished, exp_fin);
      else n_pass++;

      n_checks++;
      if (o_busy !== 1'b1)
        $display("FAIL %s busy c=%0d got %0b want 1", name, c, o_busy);
      else n_pass++;

      if (o_out_valid === 1'b1 && i_out_ready) begin
        n_checks++;
        if (got >= npix)
          $display("FAIL %s extra pixel (%0d,%0d) beyond count %0d", name, o_out_x, o_out_y, npix);
        else if (o_out_x !== ex_x[got] || o_out_y !== ex_y[got] || o_out_color !== ecol)
          $display("FAIL %s pixel %0d got (%0d,%0d,%0d) want (%0d,%0d,%0d)", name, got,
                   o_out_x, o_out_y, o_out_color, ex_x[got], ex_y[got], ecol);
        else n_pass++;
        got++;
        last_acc = c;
      end

      if (o_has_finished === 1'b1 && fin_cycle < 0) fin_cycle = c;
      prev_stall = (o_out_valid === 1'b1) && !i_out_ready;
      px = o_out_x; py = o_out_y; pc = o_out_color;

      if (fin_cycle >= 0) done = 1;
      @(posedge clk); #1;
      c++;
    end
    i_start = 1'b0;
    i_out_ready = 1'b1;

    n_checks++;
    if (!done) $display("FAIL %s timeout after %0d cycles, no has_finished", name, LIMIT);
    else n_pass++;

    n_checks++;
    if (got != npix) $display("FAIL %s pixel count got %0d want %0d", name, got, npix);
    else n_pass++;

    n_checks++;
    if (o_busy !== 1'b0 || o_has_finished !== 1'b0 || o_out_valid !== 1'b0)
      $display("FAIL %s idle after done got busy=%0b fin=%0b v=%0b want 0,0,0",
               name, o_busy, o_has_finished, o_out_valid);
    else n_pass++;

    if (stall == 0) begin
      n_checks++;
      if (fin_cycle != npix + 1)
        $display("FAIL %s finish latency got %0d want %0d", name, fin_cycle, npix + 1);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (o_out_valid !== 1'b0 || o_busy !== 1'b0 || o_has_finished !== 1'b0 ||
        o_out_x !== '0 || o_out_y !== '0 || o_out_color !== '0)
      $display("FAIL reset got v=%0b busy=%0b fin=%0b xyc=(%0d,%0d,%0d) want all 0",
               o_out_valid, o_busy, o_has_finished, o_out_x, o_out_y, o_out_color);
    else n_pass++;
    i_reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_basic();
    run_job("fill3x2", 3, 2, 1'b0, 10, 5, 5, 0, 1'b0);
  endtask

  task automatic test_outline();
    run_job("outline4x3", 4, 3, 1'b1, 0, 0, 2, 0, 1'b0);
    run_job("outline1x4", 1, 4, 1'b1, 7, 9, 1, 0, 1'b0);
    run_job("outline5x1", 5, 1, 1'b1, 3, 3, 6, 0, 1'b0);
    run_job("outline2x5", 2, 5, 1'b1, 20, 40, 4, 0, 1'b0);
  endtask

  task automatic test_stall();
    run_job("stall2x2", 2, 2, 1'b0, 30, 31, 3, 1, 1'b0);
    run_job("stall_outline6x5", 6, 5, 1'b1, 100, 60, 7, 2, 1'b0);
  endtask

  task automatic test_zero_and_ignore();
    run_job("zero_w", 0, 3, 1'b0, 1, 1, 1, 0, 1'b0);
    run_job("zero_h", 4, 0, 1'b1, 1, 1, 1, 0, 1'b0);
    run_job("ignore_start", 3, 3, 1'b0, 50, 20, 6, 0, 1'b1);
  endtask

  task automatic test_wrap();
    run_job("wrap4x3", 4, 3, 1'b0, 254, 126, 5, 0, 1'b0);
  endtask

  task automatic test_mid_reset();
    bit saw_fin;
    i_origin_x = 8'd40; i_origin_y = 7'd10; i_rect_w = 8'd5; i_rect_h = 8'd4;
    i_color = 3'd6; i_mode = 1'b0; i_out_ready = 1'b1; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    i_reset = 1'b1;
    @(posedge clk); #1;
    i_reset = 1'b0;
    n_checks++;
    if (o_out_valid !== 1'b0 || o_busy !== 1'b0 || o_has_finished !== 1'b0 ||
        o_out_x !== '0 || o_out_y !== '0)
      $display("FAIL mid_reset got v=%0b busy=%0b fin=%0b xy=(%0d,%0d) want all 0",
               o_out_valid, o_busy, o_has_finished, o_out_x, o_out_y);
    else n_pass++;
    saw_fin = 0;
    for (int k = 0; k < 6; k++) begin
      if (o_has_finished === 1'b1 || o_out_valid === 1'b1) saw_fin = 1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (saw_fin) $display("FAIL mid_reset_quiet got activity after reset want none");
    else n_pass++;
    run_job("after_reset", 3, 2, 1'b1, 12, 13, 2, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_job("b2b_a", 2, 3, 1'b0, 5, 6, 1, 0, 1'b0);
    run_job("b2b_b", 3, 3, 1'b1, 6, 7, 2, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int j = 0; j < 25; j++) begin
      int w, h;
      w = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8);
      h = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8);
      run_job($sformatf("rand%0d", j), w, h, 1'($urandom), $urandom_range(0, 255),
              $urandom_range(0, 127), $urandom_range(0, 7), $urandom_range(0, 2), 1'($urandom));
    end
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    i_reset = 1'b1; i_start = 1'b0; i_origin_x = '0; i_origin_y = '0;
    i_rect_w = '0; i_rect_h = '0; i_color = '0; i_mode = 1'b0; i_out_ready = 1'b1;
    test_reset();
    test_fill_basic();
    test_outline();
    test_stall();
    test_zero_and_ignore();
    test_wrap();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rect_renderer.md
# rect_renderer

Generalised successor to the fixed-size square scan generator. It rasterises an axis-aligned rectangle of independent width and height, in filled or outline mode, into a stream of pixel coordinates plus colour. The stream uses a valid/ready handshake, so the framebuffer/VGA write port can stall it. It sits between the shape-command decoder and the framebuffer writer in the rendering pipeline.

## Interface
- X_WIDTH, 8, bits of x coordinate
- Y_WIDTH, 7, bits of y coordinate
- SIZE_WIDTH, 8, bits of rectangle width/height
- COLOR_WIDTH, 3, bits of pixel colour

- clock  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only in IDLE
- origin_x  in  X_WIDTH  top-left x
- origin_y  in  Y_WIDTH  top-left y
- rect_w  in  SIZE_WIDTH  width in pixels
- rect_h  in  SIZE_WIDTH  height in pixels
- color  in  COLOR_WIDTH  fill colour
- mode  in  1  0 = filled, 1 = outline
- out_x  out  X_WIDTH  pixel x, registered
- out_y  out  Y_WIDTH  pixel y, registered
- out_color  out  COLOR_WIDTH  pixel colour, registered
- out_valid  out  1  pixel present
- out_ready  in  1  consumer accepts pixel
- busy  out  1  high in DRAW and DONE
- has_finished  out  1  one-cycle pulse at end of job

## Operation
- States: IDLE, DRAW, DONE.
- IDLE + start:
  - If rect_w == 0 or rect_h == 0, go to DONE; no pixels are emitted.
  - Otherwise latch origin, size, colour and mode, clear dx = dy = 0, and go to DRAW.
- start is ignored outside IDLE. Inputs are not re-sampled during a job.
- DRAW:
  - out_valid = 1.
  - out_x = (origin_x + dx) mod 2^X_WIDTH.
  - out_y = (origin_y + dy) mod 2^Y_WIDTH.
  - Coordinates wrap silently; there is no clipping.
- Advance only on handshake (out_valid && out_ready). Otherwise all outputs hold.
- Filled scan: raster order, dx fastest. After dx == w-1: dx = 0, dy++. After (w-1, h-1): go to DONE.
- Outline scan:
  - Rows dy == 0 and dy == h-1 emit every dx.
  - Interior rows emit only dx = 0 and dx = w-1; step dx from 0 straight to w-1.
  - If w == 1, each row emits a single pixel, with no duplicate.
  - If h == 1, output matches filled mode.
  - Pixel count: w*h if w ≤ 2 or h ≤ 2, else 2w + 2h − 4.
- DONE: has_finished = 1 for exactly one cycle, out_valid = 0, then go to IDLE.
- Reset, including mid-job: state IDLE; out_valid, busy and has_finished = 0; out_x, out_y, out_color, dx, dy = 0. A partially drawn job is abandoned, with no has_finished pulse.

## Timing
- start sampled at edge N; first out_valid at cycle N+1.
- With out_ready held high, one pixel per cycle. The last pixel is accepted at cycle N+P, where P is the pixel count. has_finished is high in cycle N+P+1. IDLE is reached at N+P+2, and a new start is accepted there.
- Zero-size job: has_finished in cycle N+1.
- out_ready may toggle freely. out_valid never drops in DRAW before the last handshake.
- out_ready is ignored when out_valid == 0.
- Counter arithmetic is SIZE_WIDTH wide. Comparisons use latched w-1 and h-1, precomputed at start.

## Structure
- Shared package render_pkg holds:
  - state typedef {IDLE, DRAW, DONE}
  - mode constants MODE_FILL and MODE_OUTLINE
  - default width parameters shared with other shape renderers
- One sub-module, rect_scan_counter: dx/dy stepping with an advance input, mode and size inputs, and a last output. The top level owns the FSM, latching, coordinate add and output registers.

## Test plan
- Fill, origin (10,5), 3×2, ready = 1 → pixels (10,5)(11,5)(12,5)(10,6)(11,6)(12,6) on consecutive cycles; has_finished the cycle after the last.
- Outline 4×3 at (0,0) → 10 pixels, excluding (1,1) and (2,1), in raster order.
- Fill 2×2 with out_ready low every other cycle → exactly 4 pixels; out_x/out_y held stable while stalled; no drops or duplicates.
- rect_w = 0 → no out_valid; has_finished one cycle after start. A second start during DRAW is ignored, with no extra pixels.
- Origin (254,126), 4×3, X_WIDTH = 8, Y_WIDTH = 7 → x sequence 254, 255, 0, 1; y values 126, 127, 0 (wraps).
- Reset asserted mid-DRAW → next cycle out_valid = 0, busy = 0, no has_finished pulse; a fresh start then runs normally.
